// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART receiver and the future
// transmitter.
//   PAR_NONE/PAR_EVEN/PAR_ODD : parity-mode encodings for the PARITY parameter
//   uart_state_e              : frame FSM state encoding
//   maj3                      : 2-of-3 majority vote
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_HIGH
  } uart_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fifo_gen2_if.sv
// uart_rx_fifo_gen2_if: host-side handshake bundle of the UART receiver.
//   Data/ParityErr/FrameErr : head-of-FIFO word and its flags
//   Valid/Ack               : FIFO non-empty / pop request
//   Overrun/ClrOvr          : sticky drop flag and its clear
//   Busy                    : frame FSM not idle
// slave = receiver side, master = host side.
interface uart_rx_fifo_gen2_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] Data;
  logic                 ParityErr;
  logic                 FrameErr;
  logic                 Valid;
  logic                 Ack;
  logic                 Overrun;
  logic                 ClrOvr;
  logic                 Busy;

  modport master (
    input  Data, ParityErr, FrameErr, Valid, Overrun, Busy,
    output Ack, ClrOvr
  );

  modport slave (
    output Data, ParityErr, FrameErr, Valid, Overrun, Busy,
    input  Ack, ClrOvr
  );
endinterface

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock first-word-fall-through FIFO.
//   clk, rst_n     : clock, async active-low reset
//   i_push/i_wdata : write request and word
//   i_pop          : read request (ignored when empty)
//   o_rdata        : head word, forced to 0 while empty
//   o_full/o_empty : status
// A push while full is accepted only if a pop happens in the same cycle.
module uart_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  // When full, the write slot is the head slot being popped this cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

  assign o_rdata = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

endmodule

// File: rtl/uart_rx_fifo_gen2.sv
// uart_rx_fifo_gen2: parametrised UART receiver with receive FIFO.
//   Clk   : system clock
//   Reset : async active-low reset, release synchronised internally
//   Rx    : asynchronous serial input, idle high
//   bus   : host interface (Data, ParityErr, FrameErr, Valid, Ack,
//           Overrun, ClrOvr, Busy)
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 majority sampling around
// the bit centre (needs CLK_DIV >= 8); without it a single centre sample.
//
// state        | meaning
// ST_IDLE      | waiting for a falling edge on srx
// ST_START     | timing to mid start bit, rejects false starts
// ST_DATA      | sampling DATA_BITS data bits, LSB first
// ST_PARITY    | sampling and checking the parity bit
// ST_STOP      | sampling STOP_BITS stop bits, pushes the word
// ST_WAIT_HIGH | line held low after a frame, waiting for idle
module uart_rx_fifo_gen2
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Rx,
  uart_rx_fifo_gen2_if.slave  bus
);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] HALF      = CW'(CLK_DIV/2 - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
`ifdef UART_RX_MAJORITY_EN
  // The advance happens one cycle after count 0, so reload one less.
  localparam logic [CW-1:0] RELOAD    = CW'(CLK_DIV - 2);
`else
  localparam logic [CW-1:0] RELOAD    = CW'(CLK_DIV - 1);
`endif

  logic [1:0]           r_rst_sync;
  logic                 w_rst_n;
  logic                 r_rx_meta;
  logic                 r_srx;
  uart_state_e          r_state, w_state_nxt;
  logic [CW-1:0]        r_cnt, w_cnt_nxt;
  logic [3:0]           r_idx, w_idx_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic                 r_perr, w_perr_nxt;
  logic                 r_ferr, w_ferr_nxt;
  logic                 w_push;
  logic                 w_counting;
  logic                 w_tick;
  logic                 w_bit;
  logic                 w_par_exp;
  logic [DATA_BITS+1:0] w_head;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_pop;
  logic                 r_overrun;

  // Async assert, synchronous release.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) r_rst_sync <= '0;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  // Reset to the idle level so release never looks like a start edge.
  always_ff @(posedge Clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_rx_meta <= 1'b1;
      r_srx     <= 1'b1;
    end else begin
      r_rx_meta <= Rx;
      r_srx     <= r_rx_meta;
    end
  end

  assign w_counting = (r_state == ST_START) || (r_state == ST_DATA) ||
                      (r_state == ST_PARITY) || (r_state == ST_STOP);

`ifdef UART_RX_MAJORITY_EN
  logic r_v1, r_v0, r_tick_d;

  always_ff @(posedge Clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_v1     <= 1'b1;
      r_v0     <= 1'b1;
      r_tick_d <= 1'b0;
    end else begin
      if (r_cnt == CW'(1)) r_v1 <= r_srx;
      if (r_cnt == '0)     r_v0 <= r_srx;
      r_tick_d <= w_counting && (r_cnt == '0) && !r_tick_d;
    end
  end

  assign w_tick = r_tick_d;
  assign w_bit  = maj3(r_v1, r_v0, r_srx);
`else
  assign w_tick = w_counting && (r_cnt == '0);
  assign w_bit  = r_srx;
`endif

  assign w_par_exp = (PARITY == PAR_ODD) ? ~(^r_shift) : ^r_shift;

  always_ff @(posedge Clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_perr  <= w_perr_nxt;
      r_ferr  <= w_ferr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_perr_nxt  = r_perr;
    w_ferr_nxt  = r_ferr;
    w_push      = 1'b0;

    // Counter parks at 0 until the tick consumes it.
    if (w_counting && (r_cnt != '0)) w_cnt_nxt = r_cnt - 1'b1;

    case (r_state)
      ST_IDLE: begin
        if (!r_srx) begin
          w_state_nxt = ST_START;
          w_cnt_nxt   = HALF;
        end
      end
      ST_START: begin
        if (w_tick) begin
          if (w_bit) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_DATA;
            w_cnt_nxt   = RELOAD;
            w_idx_nxt   = '0;
            w_perr_nxt  = 1'b0;
            w_ferr_nxt  = 1'b0;
          end
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          w_shift_nxt = {w_bit, r_shift[DATA_BITS-1:1]};
          w_cnt_nxt   = RELOAD;
          if (r_idx == LAST_DATA) begin
            w_idx_nxt   = '0;
            w_state_nxt = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (w_tick) begin
          if (w_bit != w_par_exp) w_perr_nxt = 1'b1;
          w_cnt_nxt   = RELOAD;
          w_idx_nxt   = '0;
          w_state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          if (!w_bit) w_ferr_nxt = 1'b1;
          w_cnt_nxt = RELOAD;
          if (r_idx == LAST_STOP) begin
            w_push      = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = w_bit ? ST_IDLE : ST_WAIT_HIGH;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      ST_WAIT_HIGH: begin
        if (r_srx) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_pop = !w_empty && bus.Ack;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (Clk),
    .rst_n   (w_rst_n),
    .i_push  (w_push),
    .i_wdata ({w_ferr_nxt, r_perr, r_shift}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Set wins over clear.
  always_ff @(posedge Clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_overrun <= 1'b0;
    end else if (w_push && w_full && !w_pop) begin
      r_overrun <= 1'b1;
    end else if (bus.ClrOvr) begin
      r_overrun <= 1'b0;
    end
  end

  assign bus.Data      = w_head[DATA_BITS-1:0];
  assign bus.ParityErr = w_head[DATA_BITS];
  assign bus.FrameErr  = w_head[DATA_BITS+1];
  assign bus.Valid     = !w_empty;
  assign bus.Overrun   = r_overrun;
  assign bus.Busy      = (r_state != ST_IDLE);

endmodule
